// File: rtl/halfword_burst_arbiter.sv
// -----------------------------------------------------------------------------
// halfword_burst_arbiter
//
// Shares the reader side of one half-width-read FIFO between two consumers.
// Each consumer asks for a burst of N halfwords. Bursts are granted
// round-robin, and each burst is streamed out as full-word beats (two
// halfwords) and at most one trailing half-word beat.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req[1:0]              - per-requester burst request, held until granted
//   req_len0 / req_len1   - burst length in halfwords, sampled at grant
//   grant[1:0]            - one-hot owner of the current burst, 0 when idle
//   done[1:0]             - one-cycle pulse to the owner after its last beat
//   out_valid/out_ready   - output beat handshake
//   out_data              - beat data (only the low half is meaningful on half beats)
//   out_half              - current beat carries a single halfword
//   fifo_read             - FIFO read strobe (same cycle as the accepted beat)
//   fifo_only_read_half   - FIFO pops one halfword instead of two
//   fifo_dataout          - FIFO first-word-fallthrough data, next halfword low
//   fifo_fill_level       - FIFO content in halfwords
// -----------------------------------------------------------------------------
module halfword_burst_arbiter #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int MAXBURST = 64,
   parameter int FILLBITS = $clog2(DEPTH*2+1),
   parameter int LENBITS  = $clog2(MAXBURST+1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          req,
   input  logic [LENBITS-1:0]  req_len0,
   input  logic [LENBITS-1:0]  req_len1,
   output logic [1:0]          grant,
   output logic [1:0]          done,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_data,
   output logic                out_half,
   output logic                fifo_read,
   output logic                fifo_only_read_half,
   input  logic [WIDTH-1:0]    fifo_dataout,
   input  logic [FILLBITS-1:0] fifo_fill_level
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_DONE
   } state_t;

   state_t             state, state_nxt;
   logic [1:0]         grant_q, grant_nxt;
   logic [LENBITS-1:0] remaining, remaining_nxt;
   logic               last_grant, last_grant_nxt;   // index of previous owner
   logic               winner;

   logic full_ok;
   logic half_ok;
   logic beat_valid;
   logic xfer_fire;

   // Oversized requests are cut down to the largest supported burst.
   function automatic logic [LENBITS-1:0] clamp_len(input logic [LENBITS-1:0] len);
      return (len > LENBITS'(MAXBURST)) ? LENBITS'(MAXBURST) : len;
   endfunction

   // The beat type is chosen from remaining, so a full beat is only offered
   // when two halfwords are still owed; remaining can therefore never wrap.
   // A full beat is never split into halves while the FIFO is short: it stalls.
   assign full_ok    = (remaining >= LENBITS'(2)) && (fifo_fill_level >= FILLBITS'(2));
   assign half_ok    = (remaining == LENBITS'(1)) && (fifo_fill_level != '0);
   assign beat_valid = (state == S_XFER) && (full_ok || half_ok) && !reset;
   assign xfer_fire  = beat_valid && out_ready;

   // Next-state and burst bookkeeping.
   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant_q;
      remaining_nxt  = remaining;
      last_grant_nxt = last_grant;
      winner         = 1'b0;

      case (state)
         S_IDLE: begin
            if (req != 2'b00) begin
               // On a tie the requester that did not own the last burst wins.
               winner        = (req == 2'b11) ? ~last_grant : req[1];
               grant_nxt     = winner ? 2'b10 : 2'b01;
               remaining_nxt = clamp_len(winner ? req_len1 : req_len0);
               state_nxt     = S_XFER;
            end
         end

         S_XFER: begin
            if (remaining == '0) begin
               // Zero-length burst: no beats, straight to completion.
               state_nxt = S_DONE;
            end else if (xfer_fire) begin
               remaining_nxt = remaining - (half_ok ? LENBITS'(1) : LENBITS'(2));
               if (remaining_nxt == '0) begin
                  state_nxt = S_DONE;
               end
            end
         end

         S_DONE: begin
            last_grant_nxt = grant_q[1];
            grant_nxt      = 2'b00;
            state_nxt      = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
            grant_nxt = 2'b00;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         grant_q    <= 2'b00;
         remaining  <= '0;
         last_grant <= 1'b1;      // requester 0 wins the first tie
      end else begin
         state      <= state_nxt;
         grant_q    <= grant_nxt;
         remaining  <= remaining_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Outputs are forced low for as long as reset is held.
   assign grant               = reset ? 2'b00 : grant_q;
   assign done                = (!reset && state == S_DONE) ? grant_q : 2'b00;
   assign out_valid           = beat_valid;
   assign out_half            = beat_valid && half_ok;
   assign out_data            = beat_valid ? fifo_dataout : '0;
   assign fifo_read           = xfer_fire;
   assign fifo_only_read_half = xfer_fire && half_ok;

endmodule
